stereolbm_axis_cambm_mul_arb: RTL and testbench

- Shares one pipelined signed multiplier (33s x 32s -> 52, single product register with clock enable) between NUM_REQ requesters in the stereo LBM datapath.
- Each requester presents operands over a valid/ready handshake. The block arbitrates round-robin, registers operands, and multiplies.
- Returns one tagged result stream with backpressure. All pipeline stages stall together when the consumer holds off.

---
 rtl/stereolbm_axis_cambm_mul_arb.sv | 129 ++++++++++++
 tb/tb_stereolbm_axis_cambm_mul_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereolbm_axis_cambm_mul_arb.sv
// Round-robin arbiter feeding one shared two-stage signed multiplier (33s x 32s -> 52).
// A single enable stalls every stage together whenever the result register is full and unread.
module stereolbm_axis_cambm_mul_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2,
  parameter int A_W     = 33,
  parameter int B_W     = 32,
  parameter int P_W     = 52
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_p,
  output logic                   busy
);

  logic                   v1_q, v1_d, v2_q, v2_d;
  logic [A_W-1:0]         a1_q, a1_d;
  logic [B_W-1:0]         b1_q, b1_d;
  logic [ID_W-1:0]        id1_q, id1_d, id2_q, id2_d;
  logic [P_W-1:0]         p2_q, p2_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic                   arb_en_q, arb_en_d;

  logic                   ce;
  logic                   grant_vld;
  logic [ID_W-1:0]        grant;
  logic                   handshake;
  logic [A_W-1:0]         a_sel;
  logic [B_W-1:0]         b_sel;
  logic signed [P_W-1:0]  a_ext, b_ext, prod_lo;

  assign ce = ~v2_q | rsp_ready;

  // Search from rr+1 upward (wrapping); the first requester found wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_valid[i] && (((int'(rr_q) + k) % NUM_REQ) == i)) begin
          grant_vld = 1'b1;
          grant     = ID_W'(i);
        end
      end
    end
  end

  // arb_en_q keeps req_ready low while reset is held and for the first cycle after release.
  assign handshake = ce && arb_en_q && grant_vld;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = handshake && (grant == ID_W'(i));
      if (grant == ID_W'(i)) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  // Only the low P_W bits of the product are kept, so multiplying at P_W width is exact.
  assign a_ext   = P_W'($signed(a1_q));
  assign b_ext   = P_W'($signed(b1_q));
  assign prod_lo = a_ext * b_ext;

  always_comb begin
    v1_d     = v1_q;
    a1_d     = a1_q;
    b1_d     = b1_q;
    id1_d    = id1_q;
    v2_d     = v2_q;
    id2_d    = id2_q;
    p2_d     = p2_q;
    rr_d     = rr_q;
    arb_en_d = 1'b1;
    if (ce) begin
      v1_d  = handshake;
      v2_d  = v1_q;
      id2_d = id1_q;
      p2_d  = prod_lo;
      if (handshake) begin
        a1_d  = a_sel;
        b1_d  = b_sel;
        id1_d = grant;
        rr_d  = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      id1_q    <= '0;
      v2_q     <= 1'b0;
      id2_q    <= '0;
      p2_q     <= '0;
      rr_q     <= ID_W'(NUM_REQ - 1);
      arb_en_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      id1_q    <= id1_d;
      v2_q     <= v2_d;
      id2_q    <= id2_d;
      p2_q     <= p2_d;
      rr_q     <= rr_d;
      arb_en_q <= arb_en_d;
    end
  end

  assign rsp_valid = v2_q;
  assign rsp_p     = p2_q;
  assign rsp_id    = id2_q;
  assign busy      = v1_q | v2_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_mul_arb.sv
// Directed checks on a 2-requester instance plus a scoreboarded random soak on a 4-requester one.
module tb_stereolbm_axis_cambm_mul_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [1:0]   rv2, rdy2;
  logic [65:0]  a2;
  logic [63:0]  b2;
  logic         rsp_v2, rsp_r2, busy2;
  logic [1:0]   id2;
  logic [51:0]  p2;

  logic [3:0]   rv4, rdy4;
  logic [131:0] a4;
  logic [127:0] b4;
  logic         rsp_v4, rsp_r4, busy4;
  logic [1:0]   id4;
  logic [51:0]  p4;

  stereolbm_axis_cambm_mul_arb #(.NUM_REQ(2), .ID_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(rv2), .req_ready(rdy2), .req_a(a2), .req_b(b2),
    .rsp_valid(rsp_v2), .rsp_ready(rsp_r2), .rsp_id(id2), .rsp_p(p2), .busy(busy2));

  stereolbm_axis_cambm_mul_arb #(.NUM_REQ(4), .ID_W(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(rv4), .req_ready(rdy4), .req_a(a4), .req_b(b4),
    .rsp_valid(rsp_v4), .rsp_ready(rsp_r4), .rsp_id(id4), .rsp_p(p4), .busy(busy4));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [51:0] ref_p(input logic [32:0] a, input logic [31:0] b);
    logic signed [64:0] f;
    f = $signed(a) * $signed(b);
    return f[51:0];
  endfunction

  task automatic set2(input logic [1:0] v, input logic [32:0] a0, input logic [31:0] b0,
                      input logic [32:0] a1, input logic [31:0] b1);
    rv2 = v;
    a2  = {a1, a0};
    b2  = {b1, b0};
  endtask

  task automatic single(input string tag, input logic [32:0] a, input logic [31:0] b,
                        input logic [51:0] exp);
    @(negedge clk);
    set2(2'b01, a, b, '0, '0);
    #1 chk({tag, "_rdy"}, rdy2, 2'b01);
    @(negedge clk);
    rv2 = 2'b00;
    chk({tag, "_early"}, rsp_v2, 1'b0);
    chk({tag, "_busy"}, busy2, 1'b1);
    @(negedge clk);
    chk({tag, "_v"}, rsp_v2, 1'b1);
    chk({tag, "_id"}, id2, 2'd0);
    chk({tag, "_p"}, p2, exp);
    @(negedge clk);
    chk({tag, "_once"}, rsp_v2, 1'b0);
    chk({tag, "_idle"}, busy2, 1'b0);
  endtask

  // Requesters must keep operands stable from valid until handshake.
  logic [3:0]   pv, prdy;
  logic [131:0] pa;
  logic [127:0] pb;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (pv[i] === 1'b1 && prdy[i] === 1'b0 && rv4[i])
        assert (a4[i*33 +: 33] == pa[i*33 +: 33] && b4[i*32 +: 32] == pb[i*32 +: 32])
          else $error("operands changed while pending on requester %0d", i);
    pv   <= rv4;
    prdy <= rdy4;
    pa   <= a4;
    pb   <= b4;
  end

  typedef struct packed {logic [1:0] id; logic [51:0] p;} exp_t;
  exp_t q[$];
  logic [32:0] sa [4];
  logic [31:0] sb [4];
  logic [3:0]  granted;
  int          waits [4];
  int          max_wait;
  int          n_res;

  initial begin
    reset_n = 1'b0;
    set2(2'b11, 33'd1, 32'd1, 33'd1, 32'd1);
    rsp_r2 = 1'b1;
    rv4 = '0; a4 = '0; b4 = '0; rsp_r4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_v", rsp_v2, 1'b0);
    chk("rst_p", p2, 52'd0);
    chk("rst_id", id2, 2'd0);
    chk("rst_rdy", rdy2, 2'b00);
    chk("rst_busy", busy2, 1'b0);
    reset_n = 1'b1;
    rv2 = 2'b00;
    @(negedge clk);

    // contention: both held valid for 6 grants
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2 && c < 8) begin
        chk("cont_v", rsp_v2, 1'b1);
        chk("cont_id", id2, 2'((c - 2) % 2));
        chk("cont_p", p2, ((c - 2) % 2) ? 52'hF_FFFF_FFFF_FFF4 : 52'hE);
      end else begin
        chk("cont_idle", rsp_v2, 1'b0);
      end
      if (c < 6) begin
        set2(2'b11, 33'd7, 32'd2, 33'h1_FFFF_FFFD, 32'd4);
        #1 chk("cont_rdy", rdy2, (c % 2) ? 2'b10 : 2'b01);
      end else begin
        rv2 = 2'b00;
      end
    end

    single("neg15", 33'd3, 32'hFFFF_FFFB, 52'hF_FFFF_FFFF_FFF1);
    single("minmin", 33'h1_0000_0000, 32'h8000_0000, 52'h0);
    single("m1m1", 33'h1_FFFF_FFFF, 32'hFFFF_FFFF, 52'h1);
    single("maxmax", 33'h0_FFFF_FFFF, 32'h7FFF_FFFF, 52'hF_FFFE_8000_0001);
    single("maxmin", 33'h0_FFFF_FFFF, 32'h8000_0000, 52'h0_0000_8000_0000);
    single("small", 33'd12345, 32'd1000, 52'hBC5EA8);

    // backpressure: two results queued, consumer holds off for 5 cycles
    @(negedge clk);
    set2(2'b01, 33'd5, 32'd6, 33'h1_FFFF_FFF9, 32'd8);
    @(negedge clk);
    rv2 = 2'b10;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_v", rsp_v2, 1'b1);
      chk("bp_id", id2, 2'd0);
      chk("bp_p", p2, 52'd30);
      chk("bp_busy", busy2, 1'b1);
      set2(2'b01, 33'd9, 32'd9, 33'h1_FFFF_FFF9, 32'd8);
      rsp_r2 = (c == 5);
      #1 chk("bp_rdy", rdy2, (c == 5) ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    rv2 = 2'b00;
    chk("bp_d1_id", id2, 2'd1);
    chk("bp_d1_p", p2, 52'hF_FFFF_FFFF_FFC8);
    @(negedge clk);
    chk("bp_d2_v", rsp_v2, 1'b1);
    chk("bp_d2_id", id2, 2'd0);
    chk("bp_d2_p", p2, 52'd81);
    @(negedge clk);
    chk("bp_done", rsp_v2, 1'b0);

    // reset while both stages hold an operation
    set2(2'b11, 33'd2, 32'd3, 33'd4, 32'd5);
    @(negedge clk);
    @(negedge clk);
    chk("mr_busy_pre", busy2, 1'b1);
    chk("mr_v_pre", rsp_v2, 1'b1);
    chk("mr_id_pre", id2, 2'd1);
    chk("mr_p_pre", p2, 52'd20);
    reset_n = 1'b0;
    #1;
    chk("mr_v", rsp_v2, 1'b0);
    chk("mr_busy", busy2, 1'b0);
    chk("mr_rdy", rdy2, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("mr_rdy_rel", rdy2, 2'b00);
    @(negedge clk);
    chk("mr_no_ghost", rsp_v2, 1'b0);
    #1 chk("mr_first", rdy2, 2'b01);
    @(negedge clk);
    rv2 = 2'b00;
    chk("mr_no_ghost2", rsp_v2, 1'b0);
    @(negedge clk);
    chk("mr_res_v", rsp_v2, 1'b1);
    chk("mr_res_id", id2, 2'd0);
    chk("mr_res_p", p2, 52'd6);
    @(negedge clk);
    chk("mr_end", rsp_v2, 1'b0);

    // random soak on the 4-requester instance
    granted = '0;
    max_wait = 0;
    n_res = 0;
    for (int i = 0; i < 4; i++) begin
      waits[i] = 0; sa[i] = '0; sb[i] = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (granted[i]) rv4[i] = 1'b0;
        if (!rv4[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            sa[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
            sb[i] = 32'($urandom);
            rv4[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rv4[i] = 1'b0;
        end
        a4[i*33 +: 33] = sa[i];
        b4[i*32 +: 32] = sb[i];
      end
      rsp_r4 = ($urandom_range(0, 3) != 0);
      #1;
      granted = rv4 & rdy4;
      chk("soak_onehot", ($countones(rdy4) <= 1), 1'b1);
      if (rsp_v4 && !rsp_r4) chk("soak_stall_rdy", rdy4, 4'b0);
      if (rsp_v4 && rsp_r4) begin
        if (q.size() == 0) begin
          chk("soak_unexpected", rsp_v4, 1'b0);
        end else begin
          chk("soak_id", id4, q[0].id);
          chk("soak_p", p4, q[0].p);
          void'(q.pop_front());
          n_res++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (granted[i]) begin
          q.push_back({2'(i), ref_p(sa[i], sb[i])});
          for (int j = 0; j < 4; j++)
            if (j != i) begin
              if (rv4[j]) waits[j]++;
              if (waits[j] > max_wait) max_wait = waits[j];
            end
          waits[i] = 0;
        end else if (!rv4[i]) begin
          waits[i] = 0;
        end
      end
    end
    @(negedge clk);
    rv4 = '0;
    rsp_r4 = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      if (rsp_v4) begin
        chk("drain_id", id4, q[0].id);
        chk("drain_p", p4, q[0].p);
        void'(q.pop_front());
        n_res++;
      end
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", busy4, 1'b0);
    chk("soak_starve", (max_wait <= 3), 1'b1);
    chk("soak_volume", (n_res > 1000), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
